// File: rtl/ps2_keyfifo_pkg.sv
// Shared constants and types for the PS/2 key event queue: register map,
// prefix bytes, prefix-tracking states and the queued entry width.
package ps2_keyfifo_pkg;

    localparam logic [15:0] KF_DATA = 16'hFFB0;
    localparam logic [15:0] KF_STAT = 16'hFFB1;
    localparam logic [15:0] KF_CNT  = 16'hFFB2;
    localparam logic [15:0] KF_ID   = 16'hFFB3;

    localparam logic [7:0] PFX_EXT  = 8'hE0;
    localparam logic [7:0] PFX_BRK  = 8'hF0;
    localparam logic [7:0] KF_ID_VAL = 8'h5A;

    localparam int ENTRY_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } pfx_state_t;

    // 00 and FF are what the receiver hands over when a frame was bad.
    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with asynchronous head read, flush, and registered
// full/empty flags. A push into a full FIFO is accepted only alongside a pop.
module sync_fifo #(
    parameter int WIDTH      = 10,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [DEPTH_LOG2:0]   count_r, count_nxt_s;
    logic                  full_r, empty_r;
    logic                  do_push_s, do_pop_s;

    // Decide which operations take effect and the resulting pointers/count.
    always_comb begin
        do_pop_s     = pop && !empty_r && !flush;
        do_push_s    = push && (!full_r || do_pop_s) && !flush;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            wr_ptr_nxt_s = '0;
            rd_ptr_nxt_s = '0;
            count_nxt_s  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            if (do_push_s && !do_pop_s) begin
                count_nxt_s = count_r + CNT_ONE;
            end else if (do_pop_s && !do_push_s) begin
                count_nxt_s = count_r - CNT_ONE;
            end else begin
                count_nxt_s = count_r;
            end
        end
    end

    // Pointer, count and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == DEPTH_CNT);
            empty_r  <= (count_nxt_s == '0);
        end
    end

    // Storage array; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/ps2_keyfifo.sv
// PS/2 key event queue: folds E0/F0 prefixes into flags, buffers events and
// exposes the queue head as CPU registers at $FFB0..$FFB3.
module ps2_keyfifo
    import ps2_keyfifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [7:0]  PS2_DATA,
    input  logic        PS2_HIT,
    input  logic [15:0] I_ADDR,
    input  logic [7:0]  I_DATA,
    input  logic        I_WREN,
    output logic [7:0]  O_DATA,
    output logic        O_SEL,
    output logic        O_IRQ
);

    pfx_state_t            state_r, state_nxt_s;
    logic                  ovf_r;
    logic                  push_req_s, pop_req_s, flush_s, ovf_clr_s, drop_s;
    logic                  ext_s, brk_s;
    logic [ENTRY_W-1:0]    entry_s, head_s;
    logic [DEPTH_LOG2:0]   count_s;
    logic                  full_s, empty_s;
    logic [7:0]            count8_s;
    logic                  unused_wdata_s;

    assign pop_req_s      = I_WREN && (I_ADDR == KF_DATA);
    assign flush_s        = I_WREN && (I_ADDR == KF_STAT) && I_DATA[0];
    assign ovf_clr_s      = I_WREN && (I_ADDR == KF_STAT) && I_DATA[1];
    assign unused_wdata_s = ^I_DATA[7:2];

    assign ext_s   = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
    assign brk_s   = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);
    assign entry_s = {ext_s, brk_s, PS2_DATA};

    // Prefix state register.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Prefix tracking; a flush also abandons any half-received prefix.
    always_comb begin
        state_nxt_s = state_r;
        push_req_s  = 1'b0;
        if (flush_s) begin
            state_nxt_s = ST_IDLE;
        end else if (PS2_HIT) begin
            if (is_err_byte(PS2_DATA)) begin
                state_nxt_s = ST_IDLE;
            end else if (PS2_DATA == PFX_EXT) begin
                case (state_r)
                    ST_IDLE: state_nxt_s = ST_EXT;
                    ST_BRK:  state_nxt_s = ST_EXT_BRK;
                    default: state_nxt_s = state_r;
                endcase
            end else if (PS2_DATA == PFX_BRK) begin
                case (state_r)
                    ST_IDLE: state_nxt_s = ST_BRK;
                    ST_EXT:  state_nxt_s = ST_EXT_BRK;
                    default: state_nxt_s = state_r;
                endcase
            end else begin
                push_req_s  = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (CLOCK),
        .rst   (RESET),
        .push  (push_req_s),
        .pop   (pop_req_s),
        .flush (flush_s),
        .din   (entry_s),
        .dout  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // A full FIFO only drops when no pop frees a slot in the same cycle.
    assign drop_s = push_req_s && full_s && !pop_req_s;

    // Sticky overflow; a drop outranks a same-cycle clear.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign O_IRQ = !empty_s;

    // Asynchronous register read mux.
    always_comb begin
        count8_s                 = 8'h00;
        count8_s[DEPTH_LOG2:0]   = count_s;
        O_SEL                    = (I_ADDR[15:2] == KF_DATA[15:2]);
        O_DATA                   = 8'h00;
        if (O_SEL) begin
            case (I_ADDR[1:0])
                2'd0:    O_DATA = empty_s ? 8'h00 : head_s[7:0];
                2'd1:    O_DATA = {head_s[9] && !empty_s, head_s[8] && !empty_s,
                                   3'b000, ovf_r, full_s, empty_s};
                2'd2:    O_DATA = count8_s;
                default: O_DATA = KF_ID_VAL;
            endcase
        end else begin
            O_DATA = 8'h00;
        end
    end

endmodule

// File: doc/ps2_keyfifo.md
# ps2_keyfifo

Buffers decoded PS/2 keyboard events between the `ps2keyboard` receiver and the CPU data bus. It folds the `E0` (extended) and `F0` (break) prefix bytes into per-event flags and queues events in a small synchronous FIFO. It exposes the head of the queue as memory-mapped registers at $FFB0..$FFB3, alongside the existing $FFA0..$FFA8 I/O map. The CPU drains events by polling and popping, with no lost keystrokes between polls.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (default 16).

Ports:
- `CLOCK` in 1: system clock (same domain as the receiver and the CPU bus).
- `RESET` in 1: synchronous, active-high reset.
- `PS2_DATA` in 8: received byte from `ps2keyboard`.
- `PS2_HIT` in 1: one-cycle strobe; `PS2_DATA` is valid in that cycle.
- `I_ADDR` in 16: CPU address.
- `I_DATA` in 8: CPU write data.
- `I_WREN` in 1: CPU write strobe. The bus master guarantees it lasts one cycle per access.
- `O_DATA` out 8: read data, valid while `O_SEL`=1, otherwise 0.
- `O_SEL` out 1: `I_ADDR` is in $FFB0..$FFB3. The top-level mux uses it.
- `O_IRQ` out 1: registered, 1 while the FIFO is not empty.

## Operation
- **Entry format, 10 bits:** `{ext, brk, code[7:0]}`.
- **Prefix FSM:**
  - States: IDLE, EXT, BRK, EXT_BRK.
  - On a `PS2_HIT` with byte `E0`: IDLE→EXT, BRK→EXT_BRK.
  - On `F0`: IDLE→BRK, EXT→EXT_BRK.
  - Any other byte pushes `{ext, brk, byte}`, with the flags taken from the current state, then returns to IDLE.
  - A repeated prefix (`E0` in EXT, `F0` in BRK) leaves the state unchanged.
  - `00` and `FF` (receiver errors) are dropped and force IDLE.
- **Push:**
  - Writes at the tail on the edge after `PS2_HIT`.
  - If the FIFO is full and no pop happens that cycle, the entry is dropped and sticky `ovf` is set.
- **Registers (read):**
  - $FFB0 = head `code`; 0 when empty.
  - $FFB1 = `{ext, brk, 3'b0, ovf, full, empty}` (ext and brk belong to the head entry, 0 when empty).
  - $FFB2 = count, zero-extended.
  - $FFB3 = `8'h5A` (ID).
- **Registers (write):**
  - $FFB0, any data: pop. Ignored when empty.
  - $FFB1: bit0 = 1 flushes the FIFO and forces the FSM to IDLE; bit1 = 1 clears `ovf`. Both bits may be set in the same write.
  - $FFB2 and $FFB3 writes are ignored.
- **Simultaneous events:**
  - Push + pop, not empty: both occur and count is unchanged. This includes the full case, where the push is accepted.
  - Push + pop, empty: push only.
  - Flush + push in the same cycle: the flush wins and the byte is discarded.
  - Push + `ovf`-clear in a full cycle without pop: `ovf` ends up 1.
- **Pointers:** `DEPTH_LOG2`-bit pointers that wrap modulo depth. Count is `DEPTH_LOG2+1` bits. full = (count == 2^DEPTH_LOG2), empty = (count == 0).

## Timing
- **Reset values:**
  - Pointers 0, count 0, `ovf` 0, FSM IDLE, `O_IRQ` 0.
  - `O_SEL` and `O_DATA` are combinational from `I_ADDR` and state. With the FIFO empty after reset, a read of $FFB1 returns `8'h01`.
  - Asserting `RESET` mid-sequence (e.g. after `E0`) discards the pending prefix.
- **Read path:** combinational, zero-latency, consistent with the asynchronous-read I/O map of the top level. It reflects state as of the last clock edge.
- **Push latency:** `PS2_HIT` in cycle n → entry visible (empty=0, count+1) and `O_IRQ`=1 from cycle n+1.
- **Pop latency:** write in cycle n → the new head is visible in cycle n+1. `O_IRQ` falls in n+1 if the FIFO became empty.
- **Throughput:** one push and one pop per cycle maximum. `PS2_HIT` spacing from the receiver is far larger, so there is no backpressure toward the receiver.

## Structure
- Package `ps2_keyfifo_pkg`:
  - Address constants `KF_DATA`=$FFB0, `KF_STAT`=$FFB1, `KF_CNT`=$FFB2, `KF_ID`=$FFB3.
  - Prefix constants `8'hE0` and `8'hF0`, and ID `8'h5A`.
  - FSM state enum; entry width 10.
- Sub-module `sync_fifo`:
  - Parameters: width, log2 depth.
  - Ports: push, pop, flush, din, dout (head, asynchronous read), count, full, empty.
  - Reusable for a later UART receive queue.
- The top module holds the prefix FSM, `ovf`, the register decode and `O_IRQ`.

## Test plan
- **Extended break:** after reset, feed `E0`,`F0`,`75` → count=1; $FFB0=`75`; $FFB1=`C0` (ext=1, brk=1); write $FFB0 → $FFB1=`01`, `O_IRQ`=0.
- **Prefix discard on reset:** feed `1C`, then `E0`, assert `RESET`, release, feed `1C` → only the entry `{0,0,1C}` remains after reset; ext=0.
- **Overflow:**
  - Push 17 plain codes `01`..`11` with no pops → count=16 and $FFB1=`06` (ovf=1, full=1); $FFB0=`01`.
  - Popping 16 times yields `01`..`10` in order (the 17th is lost).
  - Write $FFB1 with `02` → ovf=0.
- **Push and pop together:** fill the FIFO to 16, then assert `PS2_HIT` (`2A`) and a $FFB0 write in the same cycle → count stays 16, ovf=0, and the tail entry after 15 further pops is `2A`.
- **Flush priority and error drop:**
  - With 3 entries, write $FFB1=`01` in the same cycle as `PS2_HIT`=`33` → count=0.
  - Then feed `F0`,`00`,`21` → entry `{0,0,21}` (the error byte cleared the prefix).
- **Decode:** reads at $FFB3 → `5A`, `O_SEL`=1; at $FFB4 → `O_SEL`=0, `O_DATA`=0.
